i2c_target: RTL
===============

# i2c_target

I2C target (responder) emulating a 24Cxx-style 256-byte EEPROM on the shared SCL/SDA pair. It is the far end of the existing I2C controller: it decodes START/STOP, matches a 7-bit device address, and accepts the 8-bit byte-address write. It then performs sequential writes into internal memory or sequential reads out of it, including controller-driven repeated START. It sits on the board-side I2C pins and provides a golden peer for controller bring-up and trojan-detection experiments.

## Interface
- `DEV_ADDR`, 7'h50, 7-bit device address this target answers to.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `scl_in`  in  1  raw SCL line level; asynchronous.
- `sda_in`  in  1  raw SDA line level; asynchronous.
- `sda_pull`  out  1  1 = pull SDA low, 0 = release. Open-drain; the target never drives SCL.
- `busy`  out  1  high from an address-matched START until the next STOP.
- `wr_strobe`  out  1  one-cycle pulse per data byte committed to memory.
- `wr_addr`  out  8  memory address of the committed byte; valid with `wr_strobe`.
- `wr_data`  out  8  committed byte; valid with `wr_strobe`.

## Operation
- Input conditioning:
  - `scl_in` and `sda_in` each pass through a 2-FF synchronizer.
  - One further register provides the previous synchronized value for edge detection.
- Line events, on synchronized signals:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - These take priority over all other activity.
- FSM states:
  - IDLE: wait for START.
  - ADDR: shift in 8 bits MSB first, one per SCL rise.
    - Bits[7:1] match `DEV_ADDR` → go to ADDR_ACK.
    - Mismatch → IDLE; `sda_pull` stays 0.
  - ADDR_ACK: ACK the address byte.
    - R/W = 1 → READ_DATA.
    - R/W = 0 → BYTE_ADDR.
  - BYTE_ADDR: shift in 8 bits, load them into the pointer, then BYTE_ADDR_ACK.
  - BYTE_ADDR_ACK: ACK, then WRITE_DATA.
  - WRITE_DATA: shift in 8 bits, then WRITE_ACK.
    - On the 8th SCL rise: `mem[ptr] <= byte`, pulse `wr_strobe`, `ptr <= ptr + 1`.
  - WRITE_ACK: ACK, then WRITE_DATA.
  - READ_DATA: shift out `mem[ptr]` MSB first, then READ_ACK.
  - READ_ACK: release SDA and sample the controller's response on the SCL rise.
    - ACK (0): `ptr <= ptr + 1`, then READ_DATA.
    - NACK (1): wait for STOP or START; drive nothing.
- ACK generation:
  - Assert `sda_pull` on the SCL fall that ends bit 8.
  - Release it on the following SCL fall.
- Read data:
  - `sda_pull = ~bit` is updated on every SCL fall in READ_DATA.
  - The first bit is presented on the SCL fall that ends ADDR_ACK.
- Pointer:
  - 8-bit wide; wraps 0xFF→0x00 on both reads and writes.
  - Survives STOP and repeated START (random-read = dummy write + restart read).
- START in any state → ADDR with the bit counter cleared and `sda_pull` released.
- STOP in any state → IDLE, `sda_pull` = 0, `busy` = 0.
- Memory contents are not reset.

## Timing
- Pin edge to internal event: 3 `clk` cycles (2 sync + 1 edge register).
- `sda_pull` changes on the cycle after a detected SCL fall, so data changes only while SCL is low. Requires SCL low ≥ 5 `clk` cycles; the controller's ~51-cycle half period satisfies this.
- `wr_strobe` fires 1 cycle after the detected 8th SCL rise of a data byte. It is never asserted for address or byte-address bytes.
- Reset values:
  - `sda_pull` = 0, `busy` = 0, `wr_strobe` = 0, `wr_addr` = 0, `wr_data` = 0.
  - pointer = 0, FSM = IDLE.
- Reset during a transfer releases SDA immediately (async).
- START coincident with a data SCL edge: START wins, and the partial byte is discarded with no memory write.

## Structure
- Package `i2c_pkg`:
  - FSM state encoding.
  - `I2C_ACK = 1'b0` and `I2C_NACK = 1'b1`.
  - Bit-count width.
- Sub-module `i2c_line_monitor`:
  - Synchronizers and edge registers.
  - Outputs: `scl_rise`, `scl_fall`, `start_det`, `stop_det`, synchronized `sda`.
  - Reusable by a future bus sniffer.
- Top level: FSM, shift register, pointer, 256×8 register array.

## Test plan
- Write 0xA5 to 0x10 at 7'h50 → three ACKs; `wr_strobe` pulse with `wr_addr` = 0x10, `wr_data` = 0xA5; STOP drops `busy`.
- Dummy write 0x10, repeated START, read with NACK → returns 0xA5; `sda_pull` = 0 after the NACK bit.
- Address 7'h51 → no ACK (SDA high on the 9th clock), no `wr_strobe`, `busy` stays 0.
- Write 0x11, 0x22 at pointer 0xFF → `wr_addr` 0xFF then 0x00; reading from 0xFF with ACK returns 0x11 then 0x22.
- START mid-way (after 4 bits) through a data byte → no memory write; the next address byte is ACKed normally.
- Assert `rst` low while the target holds an ACK → `sda_pull` = 0 within the same cycle; pointer = 0 after release.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared constants for the I2C target: FSM encoding,
// ACK/NACK line levels and bit-counter width.
package i2c_pkg;

  localparam int CNT_W = 4;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_ADDR      = 4'd1;
  localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
  localparam logic [3:0] ST_BADDR     = 4'd3;
  localparam logic [3:0] ST_BADDR_ACK = 4'd4;
  localparam logic [3:0] ST_WDATA     = 4'd5;
  localparam logic [3:0] ST_WACK      = 4'd6;
  localparam logic [3:0] ST_RDATA     = 4'd7;
  localparam logic [3:0] ST_RACK      = 4'd8;

endpackage

// File: rtl/i2c_line_monitor.sv
// Synchronizes raw SCL/SDA and flags clock edges plus
// START/STOP conditions on the synchronized lines.
module i2c_line_monitor
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda
);

  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_prev_q;
  logic       sda_prev_q;
  logic       scl_s;

  // Reset to the idle-bus level so release raises no false event
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_in};
      sda_sync_q <= {sda_sync_q[0], sda_in};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
    end
  end

  assign scl_s     = scl_sync_q[1];
  assign sda       = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda;

endmodule

// File: rtl/i2c_target.sv
// 24Cxx-style 256-byte EEPROM emulator on an open-drain
// I2C bus: address match, byte pointer, seq. read/write.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_pull,
  output logic       busy,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data
);

  logic scl_rise, scl_fall;
  logic start_det, stop_det, sda;

  i2c_line_monitor u_mon (
    .clk       (clk),
    .rst       (rst),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda       (sda)
  );

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       sh_q, sh_d;
  logic [7:0]       ptr_q, ptr_d;
  logic             rw_q, rw_d;
  logic             pull_q, pull_d;
  logic             busy_q, busy_d;
  logic             stb_q, stb_d;
  logic [7:0]       waddr_q, waddr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       mem_q [256];
  logic [7:0]       rx_byte, rd_byte;
  logic             we;

  assign rx_byte = {sh_q[6:0], sda};
  assign rd_byte = mem_q[ptr_q];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    ptr_d   = ptr_q;
    rw_d    = rw_q;
    pull_d  = pull_q;
    busy_d  = busy_q;
    stb_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we      = 1'b0;
    if (stop_det) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      pull_d  = 1'b0;
      busy_d  = 1'b0;
    end else if (start_det) begin
      state_d = ST_ADDR;
      cnt_d   = '0;
      pull_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_ADDR: if (scl_rise) begin
          sh_d  = rx_byte;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(7)) begin
            cnt_d = '0;
            if (rx_byte[7:1] == DEV_ADDR) begin
              state_d = ST_ADDR_ACK;
              rw_d    = rx_byte[0];
              busy_d  = 1'b1;
            end else begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end
          end
        end
        // First fall drives ACK, second fall ends the ACK bit
        ST_ADDR_ACK, ST_BADDR_ACK, ST_WACK:
          if (scl_fall) begin
            if (cnt_q == '0) begin
              pull_d = ~I2C_ACK;
              cnt_d  = CNT_W'(1);
            end else begin
              pull_d  = 1'b0;
              cnt_d   = '0;
              state_d = ST_WDATA;
              if (state_q == ST_ADDR_ACK) begin
                if (rw_q) begin
                  state_d = ST_RDATA;
                  pull_d  = ~rd_byte[7];
                  cnt_d   = CNT_W'(1);
                end else begin
                  state_d = ST_BADDR;
                end
              end
            end
          end
        ST_BADDR: if (scl_rise) begin
          sh_d  = rx_byte;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(7)) begin
            ptr_d   = rx_byte;
            cnt_d   = '0;
            state_d = ST_BADDR_ACK;
          end
        end
        ST_WDATA: if (scl_rise) begin
          sh_d  = rx_byte;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(7)) begin
            we      = 1'b1;
            stb_d   = 1'b1;
            waddr_d = ptr_q;
            wdata_d = rx_byte;
            ptr_d   = ptr_q + 8'd1;
            cnt_d   = '0;
            state_d = ST_WACK;
          end
        end
        ST_RDATA: if (scl_fall) begin
          if (cnt_q == CNT_W'(8)) begin
            pull_d  = 1'b0;
            cnt_d   = '0;
            state_d = ST_RACK;
          end else begin
            pull_d = ~rd_byte[~cnt_q[2:0]];
            cnt_d  = cnt_q + CNT_W'(1);
          end
        end
        ST_RACK: if (scl_rise) begin
          if (sda == I2C_ACK) begin
            ptr_d   = ptr_q + 8'd1;
            cnt_d   = '0;
            state_d = ST_RDATA;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      ptr_q   <= '0;
      rw_q    <= 1'b0;
      pull_q  <= 1'b0;
      busy_q  <= 1'b0;
      stb_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      ptr_q   <= ptr_d;
      rw_q    <= rw_d;
      pull_q  <= pull_d;
      busy_q  <= busy_d;
      stb_q   <= stb_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  // Storage keeps its contents across reset
  always_ff @(posedge clk) begin
    if (we) mem_q[ptr_q] <= rx_byte;
  end

  assign sda_pull  = pull_q;
  assign busy      = busy_q;
  assign wr_strobe = stb_q;
  assign wr_addr   = waddr_q;
  assign wr_data   = wdata_q;

endmodule
